// File: rtl/ysyx_22040125_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states,
// default widths and PC-select encodings.
package ysyx_22040125_pipe_ctrl_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_CNT_W  = 32;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/ysyx_22040125_sat_cnt.sv
// Saturating up-counter: advances on inc, sticks at all-ones.
module ysyx_22040125_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/ysyx_22040125_pipe_ctrl.sv
// Pipeline sequencer: merges hazard stall, EXE redirects and back-end busy
// into register enables/bubbles and PC-update select, with perf counters.
module ysyx_22040125_pipe_ctrl
    import ysyx_22040125_pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_stall,
    input  logic              redirect_req,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              if_valid,
    input  logic              if_busy,
    input  logic              mdu_busy,
    input  logic              lsu_busy,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              en_ifid,
    output logic              en_idex,
    output logic              en_exmem,
    output logic              en_memwb,
    output logic              bub_ifid,
    output logic              bub_idex,
    output logic              bub_exmem,
    output logic              bub_memwb,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redir_cnt
);

    pipe_state_e       state_reg, state_next;
    logic [ADDR_W-1:0] tgt_reg;
    logic              redir_ok;
    logic              apply;

    // A redirect can only be applied from RUN (live pulse) or HOLD (latched).
    assign redir_ok = ((state_reg == ST_RUN) && redirect_req) || (state_reg == ST_HOLD);

    always_comb begin
        pc_we      = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        en_ifid    = 1'b0;
        en_idex    = 1'b0;
        en_exmem   = 1'b0;
        en_memwb   = 1'b0;
        bub_ifid   = 1'b0;
        bub_idex   = 1'b0;
        bub_exmem  = 1'b0;
        bub_memwb  = 1'b0;
        apply      = 1'b0;
        state_next = state_reg;
        // A fresh request in HOLD supersedes the latched target.
        pc_target  = ((state_reg == ST_HOLD) && !redirect_req) ? tgt_reg : redirect_pc;

        if (!rst_n) begin
            pc_target = '0;
        end else begin
            if (lsu_busy) begin
                bub_memwb = 1'b1;
            end else if (mdu_busy) begin
                bub_exmem = 1'b1;
                en_memwb  = 1'b1;
            end else if (redir_ok) begin
                apply    = 1'b1;
                pc_we    = 1'b1;
                pc_sel   = PC_SEL_TGT;
                bub_ifid = 1'b1;
                bub_idex = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end else if (hazard_stall) begin
                bub_idex = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end else if ((state_reg == ST_DRAIN) || !if_valid) begin
                // In DRAIN any arriving response is stale and is bubbled away.
                bub_ifid = 1'b1;
                en_idex  = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end else begin
                pc_we    = 1'b1;
                en_ifid  = 1'b1;
                en_idex  = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end

            case (state_reg)
                ST_RUN: begin
                    if (apply) begin
                        state_next = if_busy ? ST_DRAIN : ST_RUN;
                    end else if (redirect_req) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (apply) begin
                        state_next = if_busy ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // HOLD drops every fetch response, so the stale one is still covered.
                    if (redirect_req) begin
                        state_next = ST_HOLD;
                    end else if (if_valid) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (redirect_req) begin
                tgt_reg <= redirect_pc;
            end
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = !pc_we;
    assign cnt_inc[1] = apply;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            ysyx_22040125_sat_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign redir_cnt = cnt_val[1];

endmodule

// File: tb/tb_ysyx_22040125_pipe_ctrl.sv
// Directed scoreboard bench for the pipeline sequencer; a narrow counter
// width lets saturation be reached in a few dozen cycles.
module tb_ysyx_22040125_pipe_ctrl;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [63:0] A1 = 64'h8000_0100;
    localparam logic [63:0] A2 = 64'h8000_0200;
    localparam logic [63:0] A3 = 64'h8000_0300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, hazard_stall, redirect_req, if_valid, if_busy, mdu_busy, lsu_busy;
    logic [ADDR_W-1:0] redirect_pc, pc_target;
    logic              pc_we, pc_sel;
    logic              en_ifid, en_idex, en_exmem, en_memwb;
    logic              bub_ifid, bub_idex, bub_exmem, bub_memwb;
    logic [CNT_W-1:0]  stall_cnt, redir_cnt;

    ysyx_22040125_pipe_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_stall (hazard_stall),
        .redirect_req (redirect_req),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_busy      (if_busy),
        .mdu_busy     (mdu_busy),
        .lsu_busy     (lsu_busy),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .pc_target    (pc_target),
        .en_ifid      (en_ifid),
        .en_idex      (en_idex),
        .en_exmem     (en_exmem),
        .en_memwb     (en_memwb),
        .bub_ifid     (bub_ifid),
        .bub_idex     (bub_idex),
        .bub_exmem    (bub_exmem),
        .bub_memwb    (bub_memwb),
        .stall_cnt    (stall_cnt),
        .redir_cnt    (redir_cnt)
    );

    typedef struct {
        logic             pc_we;
        logic             pc_sel;
        logic [63:0]      tgt;
        logic [3:0]       en;
        logic [3:0]       bub;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] rcnt;
        int               id;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_txn = 0;
    logic [CNT_W-1:0] acc_s = '0;
    logic [CNT_W-1:0] acc_r = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int id);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %0h expected %0h", id, nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the hand-computed response.
    task automatic step(input logic r, input logic hz, input logic rq, input logic [63:0] rpc,
                        input logic ifv, input logic ifb, input logic mdu, input logic lsu,
                        input logic e_we, input logic e_sel, input logic [63:0] e_tgt,
                        input logic [3:0] e_en, input logic [3:0] e_bub);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; hazard_stall = hz; redirect_req = rq; redirect_pc = rpc;
        if_valid = ifv; if_busy = ifb; mdu_busy = mdu; lsu_busy = lsu;
        e.pc_we = e_we; e.pc_sel = e_sel; e.tgt = e_tgt; e.en = e_en; e.bub = e_bub;
        e.scnt = r ? acc_s : '0;
        e.rcnt = r ? acc_r : '0;
        e.id   = n_txn;
        n_txn++;
        sb_q.push_back(e);
        if (!r) begin
            acc_s = '0;
            acc_r = '0;
        end else begin
            if (!e_we && acc_s != CNT_MAX) acc_s = acc_s + 1'b1;
            if (e_we && e_sel && acc_r != CNT_MAX) acc_r = acc_r + 1'b1;
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 64'h0, 1, 0, 0, 0, 1, 0, 64'h0, 4'b1111, 4'b0000);
    endtask

    task automatic rst_cyc();
        step(0, 0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 64'h0, 4'b0000, 4'b0000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn %0d pc_we=%0b pc_sel=%0b pc_target=%h en=%b bub=%b stall_cnt=%0d redir_cnt=%0d",
                         e.id, pc_we, pc_sel, pc_target, {en_ifid, en_idex, en_exmem, en_memwb},
                         {bub_ifid, bub_idex, bub_exmem, bub_memwb}, stall_cnt, redir_cnt);
                chk("pc_we", 64'(pc_we), 64'(e.pc_we), e.id);
                chk("pc_sel", 64'(pc_sel), 64'(e.pc_sel), e.id);
                chk("pc_target", pc_target, e.tgt, e.id);
                chk("en", 64'({en_ifid, en_idex, en_exmem, en_memwb}), 64'(e.en), e.id);
                chk("bub", 64'({bub_ifid, bub_idex, bub_exmem, bub_memwb}), 64'(e.bub), e.id);
                chk("stall_cnt", 64'(stall_cnt), 64'(e.scnt), e.id);
                chk("redir_cnt", 64'(redir_cnt), 64'(e.rcnt), e.id);
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; hazard_stall = 1'b0; redirect_req = 1'b0; redirect_pc = '0;
        if_valid = 1'b1; if_busy = 1'b0; mdu_busy = 1'b0; lsu_busy = 1'b0;

        rst_cyc(); rst_cyc();

        // Load-use stall for two cycles
        idle();
        for (int i = 0; i < 2; i++) step(1, 1, 0, 64'h0, 1, 0, 0, 0, 0, 0, 64'h0, 4'b0011, 4'b0100);
        idle(); idle();

        // Redirect with no fetch outstanding
        step(1, 0, 1, A1, 1, 0, 0, 0, 1, 1, A1, 4'b0011, 4'b1100);
        idle();

        // Redirect during a multi-cycle MDU op: held, then applied
        rst_cyc();
        step(1, 0, 1, A1, 1, 0, 1, 0, 0, 0, A1, 4'b0001, 4'b0010);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 64'h0, 1, 0, 1, 0, 0, 0, A1, 4'b0001, 4'b0010);
        step(1, 0, 0, 64'h0, 1, 0, 0, 0, 1, 1, A1, 4'b0011, 4'b1100);
        idle();

        // Redirect with fetch outstanding: drain one stale response
        step(1, 0, 1, A3, 0, 1, 0, 0, 1, 1, A3, 4'b0011, 4'b1100);
        step(1, 1, 0, 64'h0, 0, 1, 0, 0, 0, 0, 64'h0, 4'b0011, 4'b0100);
        step(1, 0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 64'h0, 4'b0111, 4'b1000);
        idle();

        // LSU busy with redirect, newer redirect in HOLD wins, hazard ignored on apply
        rst_cyc();
        step(1, 0, 1, A1, 1, 0, 0, 1, 0, 0, A1, 4'b0000, 4'b0001);
        step(1, 0, 1, A2, 1, 0, 0, 1, 0, 0, A2, 4'b0000, 4'b0001);
        step(1, 0, 0, 64'h0, 1, 0, 0, 1, 0, 0, A2, 4'b0000, 4'b0001);
        step(1, 1, 0, 64'h0, 1, 0, 0, 0, 1, 1, A2, 4'b0011, 4'b1100);
        idle(); idle();

        // Stall counter saturation
        rst_cyc();
        for (int i = 0; i < 35; i++) step(1, 1, 0, 64'h0, 1, 0, 0, 0, 0, 0, 64'h0, 4'b0011, 4'b0100);
        idle(); idle();

        // Reset in the middle of HOLD discards the pending redirect
        step(1, 0, 1, A1, 1, 0, 1, 0, 0, 0, A1, 4'b0001, 4'b0010);
        step(1, 0, 0, 64'h0, 1, 0, 1, 0, 0, 0, A1, 4'b0001, 4'b0010);
        step(0, 0, 0, A2, 1, 0, 1, 0, 0, 0, 64'h0, 4'b0000, 4'b0000);
        idle(); idle();

        @(negedge clk);
        #1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_pipe_ctrl.md
# ysyx_22040125_pipe_ctrl

Central pipeline sequencer for the five-stage RV64 core. Combines the ID-stage data-hazard stall, EXE redirects (branch/jump), and back-end busy conditions (multi-cycle MDU in EXE, LSU access in MEM) into per-register enable/bubble controls and PC-update select. Holds a redirect that arrives while the back end is frozen, and drains a stale in-flight fetch after a redirect. Also keeps saturating stall/redirect performance counters.

## Interface
- ADDR_W, 64, PC width
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- hazard_stall  in  1  load-use hazard from the hazard unit (ID stage)
- redirect_req  in  1  single-cycle pulse: EXE resolved a taken branch/jump
- redirect_pc  in  ADDR_W  target, valid with redirect_req
- if_valid  in  1  fetch response valid this cycle
- if_busy  in  1  fetch request outstanding (response not yet returned)
- mdu_busy  in  1  EXE multi-cycle op in progress
- lsu_busy  in  1  MEM access in progress
- pc_we  out  1  load PC register
- pc_sel  out  1  0 = sequential PC+4, 1 = pc_target
- pc_target  out  ADDR_W  redirect address (live or latched)
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  pipeline register enables
- bub_ifid, bub_idex, bub_exmem, bub_memwb  out  1 each  load bubble into register
- stall_cnt  out  CNT_W  cycles with pc_we=0 outside reset
- redir_cnt  out  CNT_W  redirects applied

## Operation
- States: RUN, HOLD (redirect latched, back end frozen), DRAIN (discard one stale fetch response).
- Per-cycle priority in RUN/HOLD, first match wins:
  1. lsu_busy: all enables 0, pc_we=0, bub_memwb=1.
  2. mdu_busy: pc_we, en_ifid, en_idex, en_exmem = 0; bub_exmem=1; en_memwb=1.
  3. Redirect applicable (redirect_req in RUN, or state HOLD): pc_we=1, pc_sel=1, bub_ifid=bub_idex=1, other enables 1; hazard_stall ignored. Next state DRAIN if if_busy, else RUN.
  4. hazard_stall: pc_we=0, en_ifid=0, bub_idex=1, en_exmem=en_memwb=1.
  5. if_valid=0: pc_we=0, bub_ifid=1, downstream enables 1.
  6. Otherwise all enables 1, pc_we=1, pc_sel=0.
- redirect_req while lsu_busy or mdu_busy: latch redirect_pc, go HOLD; pc_target driven from the latch while in HOLD.
- DRAIN: pc_we=0; when if_valid arrives, bub_ifid=1 (response dropped), return to RUN next cycle. Back-end rules 1-2 and hazard rule 4 still apply to downstream stages.
- A new redirect_req in DRAIN or HOLD replaces the target (newest wins); state rules otherwise unchanged.
- bub_x and en_x are never both 1 for the same register.
- Counters saturate at all-ones; redir_cnt increments on the cycle the redirect is applied (rule 3), not when latched.

## Timing
- All controls are combinational from state and current inputs, same cycle; state, latched target, and counters are registered.
- Reset (rst_n low, asynchronous): state RUN, latch 0, counters 0; while in reset all enables, bubbles, pc_we and pc_sel are 0, and pc_target is 0.
- Reset mid-HOLD/DRAIN discards the pending redirect.
- Redirect-to-first-fetch latency: 1 cycle with no fetch outstanding; 1 + drain cycles otherwise.

## Structure
- Shared package: state enum (RUN/HOLD/DRAIN), ADDR_W/CNT_W defaults, pc_sel encodings.
- One sub-module: ysyx_22040125_sat_cnt (CNT_W saturating counter with inc input), instantiated twice.

## Test plan
- hazard_stall=1 for 2 cycles, no other event -> pc_we=0, en_ifid=0, bub_idex=1 both cycles; stall_cnt=2.
- redirect_req with redirect_pc=0x8000_0100, if_busy=0 -> same cycle pc_we=1, pc_sel=1, bub_ifid=bub_idex=1; redir_cnt=1; next state RUN.
- redirect_req while mdu_busy for 3 more cycles -> HOLD, pc_target=0x8000_0100 held; redirect applied in the first cycle mdu_busy=0.
- Redirect with if_busy=1, if_valid 2 cycles later -> DRAIN, pc_we=0, dropped response gets bub_ifid=1, RUN next cycle.
- lsu_busy and redirect_req together, then second redirect to 0x8000_0200 in HOLD -> applied target 0x8000_0200, redir_cnt increments once.
- Force counter near saturation (2^CNT_W−1) then stall -> stall_cnt stays all-ones; assert rst_n low mid-HOLD -> all outputs 0, state RUN.
